// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched IRQ/NMI prioritiser and request handshake to the control unit
module interrupt_controller #(
   parameter int                  NUM_SRC    = 4,
   parameter logic [31:0]         VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0]         VEC_STRIDE = 32'd8,
   parameter logic [31:0]         NMI_VEC    = 32'h0000_0080,
   parameter logic [NUM_SRC-1:0]  MASK_RST   = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_SRC-1:0] i_irq_in,
   input  logic               i_nmi_in,
   input  logic               i_mask_wr,
   input  logic [NUM_SRC-1:0] i_mask_data,
   output logic               o_int_req,
   input  logic               i_int_ack,
   output logic               o_nmi_req,
   input  logic               i_nmi_ack,
   input  logic               i_eoi,
   output logic [31:0]        o_vector,
   output logic [2:0]         o_active_id,
   output logic               o_in_service,
   output logic [NUM_SRC-1:0] o_pending
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_INT,
      S_INT_SVC,
      S_REQ_NMI,
      S_NMI_SVC
   } state_t;

   state_t               r_state, w_state_nx;
   logic [NUM_SRC-1:0]   r_pending, r_mask, r_irq_prev;
   logic                 r_nmi_pend, r_nmi_prev;
   logic [2:0]           r_active_id, r_saved_id;
   logic                 r_nested;
   logic [31:0]          r_vector;
   logic                 r_int_req, r_nmi_req, r_in_service;

   logic [NUM_SRC-1:0]   w_irq_edge, w_masked, w_pend_clr;
   logic                 w_nmi_edge, w_nmi_clr;
   logic [2:0]           w_win_id, w_id_nx, w_saved_nx;
   logic                 w_nested_nx;
   logic [31:0]          w_vector_nx;

   function automatic logic [31:0] f_vec(input logic [2:0] id);
      return VEC_BASE + {29'd0, id} * VEC_STRIDE;
   endfunction

   assign w_irq_edge = i_irq_in & ~r_irq_prev;
   assign w_nmi_edge = i_nmi_in & ~r_nmi_prev;
   assign w_masked   = r_pending & r_mask;

   always_comb begin
      w_win_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_masked[i]) w_win_id = 3'(i);
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_id_nx     = r_active_id;
      w_saved_nx  = r_saved_id;
      w_nested_nx = r_nested;
      w_vector_nx = r_vector;
      w_pend_clr  = '0;
      w_nmi_clr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_nmi_pend) begin
               w_state_nx  = S_REQ_NMI;
               w_id_nx     = '0;
               w_vector_nx = NMI_VEC;
            end else if (|w_masked) begin
               w_state_nx  = S_REQ_INT;
               w_id_nx     = w_win_id;
               w_vector_nx = f_vec(w_win_id);
            end
         end
         S_REQ_INT: begin
            if (i_int_ack) begin
               w_pend_clr = NUM_SRC'(1) << r_active_id;
               w_state_nx = S_INT_SVC;
            end else if (r_nmi_pend) begin
               // withdrawn request stays pending and is re-arbitrated after the NMI
               w_state_nx  = S_REQ_NMI;
               w_id_nx     = '0;
               w_vector_nx = NMI_VEC;
            end
         end
         S_INT_SVC: begin
            if (i_eoi) begin
               w_state_nx = S_IDLE;
            end else if (r_nmi_pend) begin
               w_state_nx  = S_REQ_NMI;
               w_nested_nx = 1'b1;
               w_saved_nx  = r_active_id;
               w_id_nx     = '0;
               w_vector_nx = NMI_VEC;
            end
         end
         S_REQ_NMI: begin
            if (i_nmi_ack) begin
               w_nmi_clr  = 1'b1;
               w_state_nx = S_NMI_SVC;
            end
         end
         S_NMI_SVC: begin
            if (i_eoi) begin
               if (r_nested) begin
                  w_state_nx  = S_INT_SVC;
                  w_nested_nx = 1'b0;
                  w_id_nx     = r_saved_id;
                  w_vector_nx = f_vec(r_saved_id);
               end else begin
                  w_state_nx = S_IDLE;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_mask       <= MASK_RST;
         r_irq_prev   <= '0;
         r_nmi_pend   <= 1'b0;
         r_nmi_prev   <= 1'b0;
         r_active_id  <= '0;
         r_saved_id   <= '0;
         r_nested     <= 1'b0;
         r_vector     <= '0;
         r_int_req    <= 1'b0;
         r_nmi_req    <= 1'b0;
         r_in_service <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_irq_prev   <= i_irq_in;
         r_nmi_prev   <= i_nmi_in;
         // a new edge wins over a clear of the same bit
         r_pending    <= (r_pending & ~w_pend_clr) | w_irq_edge;
         r_nmi_pend   <= (r_nmi_pend & ~w_nmi_clr) | w_nmi_edge;
         if (i_mask_wr) r_mask <= i_mask_data;
         r_active_id  <= w_id_nx;
         r_saved_id   <= w_saved_nx;
         r_nested     <= w_nested_nx;
         r_vector     <= w_vector_nx;
         r_int_req    <= (w_state_nx == S_REQ_INT);
         r_nmi_req    <= (w_state_nx == S_REQ_NMI);
         r_in_service <= (w_state_nx == S_INT_SVC) || (w_state_nx == S_NMI_SVC);
      end
   end

   assign o_int_req    = r_int_req;
   assign o_nmi_req    = r_nmi_req;
   assign o_in_service = r_in_service;
   assign o_vector     = r_vector;
   assign o_active_id  = r_active_id;
   assign o_pending    = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized bench against a behavioural interrupt model
module tb_interrupt_controller;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  irq_in;
   logic          nmi_in;
   logic          mask_wr;
   logic [N-1:0]  mask_data;
   logic          int_req, int_ack, nmi_req, nmi_ack, eoi;
   logic [31:0]   vector;
   logic [2:0]    active_id;
   logic          in_service;
   logic [N-1:0]  pending;

   interrupt_controller dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(irq_in), .i_nmi_in(nmi_in),
      .i_mask_wr(mask_wr), .i_mask_data(mask_data), .o_int_req(int_req),
      .i_int_ack(int_ack), .o_nmi_req(nmi_req), .i_nmi_ack(nmi_ack), .i_eoi(eoi),
      .o_vector(vector), .o_active_id(active_id), .o_in_service(in_service),
      .o_pending(pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Model: mode 0 idle, 1 offering IRQ, 2 serving IRQ, 3 offering NMI, 4 serving NMI
   int       m_mode;
   int       m_cur;
   bit       m_nested;
   bit [N-1:0] m_pend, m_mask, m_prev;
   bit       m_npend, m_nprev;

   task automatic model_reset();
      m_mode = 0; m_cur = 0; m_nested = 0;
      m_pend = '0; m_mask = '0; m_prev = '0;
      m_npend = 0; m_nprev = 0;
   endtask

   task automatic model_step();
      bit [N-1:0] edges;
      bit         nedge;
      bit [N-1:0] eligible;
      edges    = irq_in & ~m_prev;
      nedge    = nmi_in & ~m_nprev;
      m_prev   = irq_in;
      m_nprev  = nmi_in;
      eligible = m_pend & m_mask;
      case (m_mode)
         0: if (m_npend) m_mode = 3;
            else if (eligible != 0) begin
               for (int i = 0; i < N; i++) if (eligible[i]) begin m_cur = i; break; end
               m_mode = 1;
            end
         1: if (int_ack) begin m_pend[m_cur] = 0; m_mode = 2; end
            else if (m_npend) m_mode = 3;
         2: if (eoi) m_mode = 0;
            else if (m_npend) begin m_mode = 3; m_nested = 1; end
         3: if (nmi_ack) begin m_npend = 0; m_mode = 4; end
         4: if (eoi) begin m_mode = m_nested ? 2 : 0; m_nested = 0; end
         default: m_mode = 0;
      endcase
      m_pend  = m_pend | edges;
      m_npend = m_npend | nedge;
      if (mask_wr) m_mask = mask_data;
   endtask

   task automatic compare_all();
      check("int_req", 32'(int_req), 32'(m_mode == 1));
      check("nmi_req", 32'(nmi_req), 32'(m_mode == 3));
      check("in_service", 32'(in_service), 32'(m_mode == 2 || m_mode == 4));
      check("pending", 32'(pending), 32'(m_pend));
      if (m_mode == 1) check("vector_int", vector, 32'h100 + 32'(m_cur) * 8);
      if (m_mode == 3) check("vector_nmi", vector, 32'h80);
      if (m_mode == 1 || m_mode == 2) check("active_id", 32'(active_id), 32'(m_cur));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      irq_in = '0; nmi_in = 0; mask_wr = 0; mask_data = '0;
      int_ack = 0; nmi_ack = 0; eoi = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      model_reset();
      check("rst_int_req", 32'(int_req), 0);
      check("rst_nmi_req", 32'(nmi_req), 0);
      check("rst_in_service", 32'(in_service), 0);
      check("rst_vector", vector, 0);
      check("rst_active_id", 32'(active_id), 0);
      check("rst_pending", 32'(pending), 0);
      @(negedge clk);
      idle_inputs();
      tick();
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1;
      @(negedge clk);
      do_reset();

      // T1: single source with all enabled
      mask_wr = 1; mask_data = 4'b1111; tick(); mask_wr = 0;
      irq_in = 4'b0100; tick(); tick();
      check("t1_req", 32'(int_req), 1);
      check("t1_vec", vector, 32'h110);
      check("t1_id", 32'(active_id), 2);
      irq_in = '0; int_ack = 1; tick(); int_ack = 0;
      check("t1_svc", 32'(in_service), 1);
      check("t1_pend", 32'(pending[2]), 0);
      eoi = 1; tick(); eoi = 0; tick();
      check("t1_idle", 32'(in_service), 0);

      // T2: simultaneous edges, lowest index first
      irq_in = 4'b1010; tick(); tick();
      check("t2_vec1", vector, 32'h108);
      irq_in = '0; int_ack = 1; tick(); int_ack = 0;
      eoi = 1; tick(); eoi = 0; tick();
      check("t2_vec3", vector, 32'h118);
      int_ack = 1; tick(); int_ack = 0; eoi = 1; tick(); eoi = 0; tick();

      // T3: masked source waits until unmasked
      mask_wr = 1; mask_data = 4'b0000; tick(); mask_wr = 0;
      irq_in = 4'b0001; tick(); irq_in = '0; tick(); tick();
      check("t3_noreq", 32'(int_req), 0);
      check("t3_pend", 32'(pending[0]), 1);
      mask_wr = 1; mask_data = 4'b0001; tick(); mask_wr = 0; tick();
      check("t3_vec", vector, 32'h100);

      // T4: NMI preempts an unacknowledged request
      nmi_in = 1; tick(); nmi_in = 0; tick();
      check("t4_nmi", 32'(nmi_req), 1);
      check("t4_vec", vector, 32'h80);
      nmi_ack = 1; tick(); nmi_ack = 0; eoi = 1; tick(); eoi = 0; tick();
      check("t4_rereq", 32'(int_req), 1);

      // T5: NMI nests inside an IRQ handler
      int_ack = 1; tick(); int_ack = 0;
      nmi_in = 1; tick(); nmi_in = 0; tick();
      nmi_ack = 1; tick(); nmi_ack = 0; eoi = 1; tick(); eoi = 0;
      check("t5_back", 32'(in_service), 1);
      check("t5_id", 32'(active_id), 0);
      eoi = 1; tick(); eoi = 0; tick();

      // T6: reset during NMI service with IRQs pending
      mask_wr = 1; mask_data = 4'b0000; irq_in = 4'b0110; nmi_in = 1; tick();
      mask_wr = 0; tick(); nmi_ack = 1; tick(); nmi_ack = 0;
      check("t6_nmisvc", 32'(in_service), 1);
      do_reset();

      for (int i = 0; i < 4000; i++) begin
         if (i % 997 == 600) begin
            do_reset();
         end else begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(39) == 0) nmi_in = ~nmi_in;
            mask_wr   = ($urandom_range(15) == 0);
            mask_data = N'($urandom);
            int_ack   = (int_req && $urandom_range(2) == 0) || ($urandom_range(29) == 0);
            nmi_ack   = (nmi_req && $urandom_range(1) == 0) || ($urandom_range(29) == 0);
            eoi       = ($urandom_range(5) == 0);
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
